beat_decode: RTL and testbench

//  Front end of the control path. Generates the 8-phase one-hot beats t0..t7
//  and owns the 16-bit instruction register (IR). It decodes IR[15:11] into
//  one-hot opcode strobes for the microsequencer, and drives the IR back onto
//  the data bus when the sequencer requests it. Honours the sequencer's tset
//  (beat restart). Counts retired instructions. Flags illegal opcodes.

---
 rtl/beat_decode.sv | 81 ++++++++
 tb/tb_beat_decode.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/beat_decode.sv
// Control-path front end: 8-phase one-hot beat ring, instruction register with
// registered one-hot opcode decode, IR bus driver, retire counter and illegal-opcode flag.
module beat_decode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             tset,
    input  logic             iir,
    input  logic             eir,
    input  logic [15:0]      data_in,
    output logic [7:0]       beat,
    output logic [15:0]      cmd,
    output logic [17:0]      op,
    output logic [15:0]      ir_out,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    localparam int NUM_OPS = 18;

    logic [7:0] beat_next;
    logic       retire;
    logic [4:0] opcode;
    logic       opcode_bad;
    logic [17:0] op_decoded;

    // Beat ring: tset wins, then a stopped t0 holds, otherwise rotate.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        beat_next = {beat[6:0], beat[7]};
        if (tset) begin
            beat_next = 8'h01;
        end else if (beat[0] && !run) begin
            beat_next = 8'h01;
        end
    end

    // From t7 every path (rotation or tset) lands on t0, so being at t7 means a retire.
    assign retire = beat[7];

    assign opcode     = data_in[15:11];
    assign opcode_bad = (opcode >= 5'(NUM_OPS));

    always_comb begin
        op_decoded = '0;
        if (opcode_bad) begin
            op_decoded[0] = 1'b1;
        end else begin
            op_decoded[opcode] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates share one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat    <= 8'h01;
            cmd     <= '0;
            op      <= 18'h1;
            illegal <= 1'b0;
            icount  <= '0;
        end else begin
            beat <= beat_next;
            if (retire) begin
                icount <= icount + CNT_W'(1);
            end
            // cmd and op load together so the sequencer never sees them disagree.
            if (iir) begin
                cmd <= data_in;
                op  <= op_decoded;
                if (opcode_bad) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

    assign ir_out = eir ? cmd : 16'h0000;

endmodule

// File: tb/tb_beat_decode.sv
// Randomized scoreboard bench for beat_decode: a phase/opcode-level model predicts
// each cycle's outputs, a monitor compares them as the DUT presents them.
module tb_beat_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0, tset = 1'b0, iir = 1'b0, eir = 1'b0;
    logic [15:0] data_in = '0;

    logic [7:0]  beat, beat_s;
    logic [15:0] cmd, cmd_s, ir_out, ir_out_s;
    logic [17:0] op, op_s;
    logic        illegal, illegal_s;
    logic [15:0] icount;
    logic [3:0]  icount_s;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] ir_pre;
        logic [7:0]  beat;
        logic [15:0] cmd;
        logic [17:0] op;
        logic        illegal;
        logic [15:0] icount;
        logic [3:0]  icount_s;
    } exp_t;

    exp_t q[$];

    // Reference model state, kept as phase number / opcode number
    int          phase;
    logic [15:0] m_cmd;
    int          m_opv;
    bit          m_illegal;
    int unsigned m_count;

    beat_decode #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .tset(tset), .iir(iir), .eir(eir),
        .data_in(data_in), .beat(beat), .cmd(cmd), .op(op), .ir_out(ir_out),
        .illegal(illegal), .icount(icount)
    );

    // Narrow-counter copy exercises the modulo wrap in a reachable number of cycles.
    beat_decode #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .run(run), .tset(tset), .iir(iir), .eir(eir),
        .data_in(data_in), .beat(beat_s), .cmd(cmd_s), .op(op_s), .ir_out(ir_out_s),
        .illegal(illegal_s), .icount(icount_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] op_of(input int v);
        logic [17:0] r;
        r = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        phase = 0;
        m_cmd = '0;
        m_opv = 0;
        m_illegal = 1'b0;
        m_count = 0;
    endtask

    // Called at posedge+2: drive inputs for the coming edge, predict, then let the edge pass.
    task automatic step(input bit r, input bit t, input bit i, input bit e, input logic [15:0] d);
        exp_t ex;
        int   opc;
        run = r; tset = t; iir = i; eir = e; data_in = d;
        ex.ir_pre = e ? m_cmd : 16'h0000;
        if (t) begin
            if (phase == 7) m_count++;
            phase = 0;
        end else if (!(phase == 0 && !r)) begin
            if (phase == 7) m_count++;
            phase = (phase + 1) % 8;
        end
        if (i) begin
            opc = int'(d[15:11]);
            m_cmd = d;
            if (opc < 18) begin
                m_opv = opc;
            end else begin
                m_opv = 0;
                m_illegal = 1'b1;
            end
        end
        ex.beat     = 8'(1 << phase);
        ex.cmd      = m_cmd;
        ex.op       = op_of(m_opv);
        ex.illegal  = m_illegal;
        ex.icount   = m_count[15:0];
        ex.icount_s = m_count[3:0];
        q.push_back(ex);
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("queue_drain", 32'(q.size()), 32'd0);
    endtask

    task automatic goto_phase(input int k);
        for (int n = 0; n < 8 && phase != k; n++) step(1, 0, 0, 0, 16'h0000);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_beat"}, 32'(beat), 32'h01);
        check({tag, "_cmd"}, 32'(cmd), 32'h0);
        check({tag, "_op"}, 32'(op), 32'h1);
        check({tag, "_illegal"}, 32'(illegal), 32'h0);
        check({tag, "_icount"}, 32'(icount), 32'h0);
        check({tag, "_icount_s"}, 32'(icount_s), 32'h0);
        check({tag, "_ir_out"}, 32'(ir_out), 32'h0);
    endtask

    // Async reset at posedge+3, observed before any edge, released at the next posedge+2.
    task automatic pulse_reset(input string tag);
        drain();
        #1;
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pre-edge ir_out at the negedge, registered state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q[0];
                check("ir_out", 32'(ir_out), 32'(e.ir_pre));
                @(posedge clk);
                #1;
                check("beat", 32'(beat), 32'(e.beat));
                check("cmd", 32'(cmd), 32'(e.cmd));
                check("op", 32'(op), 32'(e.op));
                check("illegal", 32'(illegal), 32'(e.illegal));
                check("icount", 32'(icount), 32'(e.icount));
                check("icount_s", 32'(icount_s), 32'(e.icount_s));
                check("beat_s", 32'(beat_s), 32'(e.beat));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("por");
        reset = 1'b0;

        // Free-running beats: two retires in 16 edges
        for (int n = 0; n < 16; n++) step(1, 0, 0, 0, 16'h0000);
        check("walk_icount", 32'(icount), 32'd2);
        check("walk_beat", 32'(beat), 32'h01);

        // add dst1 src4, and same-edge iir+eir shows old cmd pre-edge
        step(1, 0, 1, 1, 16'h3104);
        check("add_op", 32'(op), 32'h40);
        check("add_cmd", 32'(cmd), 32'h3104);
        step(1, 0, 0, 1, 16'h0000);

        // Illegal opcode 31, then a legal load leaves the flag set
        step(1, 0, 1, 0, 16'hF800);
        check("bad_op", 32'(op), 32'h1);
        check("bad_flag", 32'(illegal), 32'h1);
        step(1, 0, 1, 1, 16'h8800);
        check("sticky_flag", 32'(illegal), 32'h1);
        check("pop_op", 32'(op), 32'h20000);
        pulse_reset("rst_a");

        // tset at t4 does not retire; tset at t7 does
        goto_phase(4);
        step(1, 1, 0, 0, 16'h0000);
        check("tset4_beat", 32'(beat), 32'h01);
        check("tset4_icount", 32'(icount), 32'd0);
        goto_phase(7);
        step(1, 1, 0, 0, 16'h0000);
        check("tset7_icount", 32'(icount), 32'd1);
        step(0, 1, 0, 0, 16'h0000);

        // run dropped at t3 finishes the instruction then parks at t0
        goto_phase(3);
        for (int n = 0; n < 7; n++) step(0, 0, 0, 0, 16'h0000);
        check("park_beat", 32'(beat), 32'h01);
        step(1, 0, 0, 0, 16'h0000);
        check("resume_beat", 32'(beat), 32'h02);

        // Mid-instruction reset with a loaded IR
        step(1, 0, 1, 1, 16'h8000);
        goto_phase(5);
        pulse_reset("rst_t5");

        // Randomized traffic with occasional async resets
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 16'($urandom));
            if (n % 1000 == 999) pulse_reset("rst_rand");
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
